wb_stage_reg: RTL
=================

# wb_stage_reg

Registered, parametrised MIPS writeback stage: the MEM/WB pipeline register plus the writeback result mux, with sub-word load extraction, link-address writeback, stall/flush control and a retired-instruction counter. It sits between the memory stage and the register file write port. Its registered outputs also feed the WB→EX forwarding path.

## Interface
Parameters:
- DATA_W, 32, datapath width; legal values are 32 or 64.
- RADDR_W, 5, register-file address width.
- CNT_W, 32, retire counter width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- stall  in  1  hold the stage register
- flush  in  1  replace the incoming instruction with a bubble
- in_valid  in  1  MEM stage holds a real instruction
- mem_data  in  DATA_W  raw load data (aligned word/dword)
- alu_result  in  DATA_W  ALU result
- link_addr  in  DATA_W  return address for JAL/JALR (PC+8)
- src_sel  in  2  result source: 0 ALU, 1 memory, 2 link, 3 reserved (treated as ALU)
- load_size  in  2  0 byte, 1 half, 2 word, 3 dword (3 is word when DATA_W=32)
- load_unsigned  in  1  zero-extend instead of sign-extend
- byte_off  in  $clog2(DATA_W/8)  byte offset of the load address
- reg_write  in  1  instruction writes the register file
- wr_addr  in  RADDR_W  destination register
- wb_valid  out  1  registered valid
- wb_reg_write  out  1  register-file write enable
- wb_data  out  DATA_W  writeback data
- wb_addr  out  RADDR_W  writeback destination
- retire_count  out  CNT_W  number of retired valid instructions

## Operation
- Result mux, combinational on the inputs, ahead of the register:
  - src 0 or 3 → alu_result
  - src 1 → extracted load value
  - src 2 → link_addr
- Load extraction:
  - Select the lane at byte_off: byte lane = byte_off; half lane = byte_off>>1; word lane = byte_off>>2 (DATA_W=64 only).
  - Low bits of byte_off that fall inside the lane are ignored. Misalignment traps are handled elsewhere.
  - Extend the lane to DATA_W: sign-extend, or zero-extend when load_unsigned=1. Dword passes unchanged.
- Write enable: wb_reg_write = reg_write & in_valid & (wr_addr != 0). Writes to $zero are always suppressed.
- Stage register update, in priority order:
  1. reset: all outputs cleared.
  2. flush: wb_valid=0 and wb_reg_write=0. wb_data and wb_addr are also cleared to 0 so bubbles are deterministic.
  3. stall: all outputs hold.
  4. Otherwise: load the new values.
- Retire counter:
  - Increments on a clock edge when the register loads a new entry with in_valid=1 (no reset, flush or stall).
  - Wraps modulo 2^CNT_W.
  - An instruction held by stall is counted once, when it is loaded.

## Timing
- Latency: 1 cycle from the MEM-stage inputs to the wb_* outputs.
- All outputs are registered. No combinational input→output path.
- Reset values: wb_valid=0, wb_reg_write=0, wb_data=0, wb_addr=0, retire_count=0.
- Reset asserted mid-stall or mid-flush clears everything on the next edge. The counter also clears.
- stall and flush together: flush wins and a bubble is inserted.
- in_valid=0 with reg_write=1: wb_reg_write=0 and wb_valid=0. Data is still registered and the counter is unchanged.
- Counter at all-ones plus one retirement → 0.

## Configuration
- WB_LOAD_EXT_EN
  - Defined: sub-word extraction and extension as described above.
  - Undefined: the extraction logic is compiled out. src 1 returns mem_data unmodified; load_size, load_unsigned and byte_off are ignored.

## Structure
- Shared package mips_pkg holds:
  - the src_sel encodings (WB_SRC_ALU, WB_SRC_MEM, WB_SRC_LINK)
  - the load_size encodings (LD_BYTE, LD_HALF, LD_WORD, LD_DWORD)
- One sub-module, load_extract (purely combinational):
  - inputs: mem_data, load_size, load_unsigned, byte_off
  - output: extended value
- The result mux, stage register and counter live in wb_stage_reg.

## Test plan
- Reset, then src=0, alu_result=0x0000_1234, wr_addr=8, reg_write=1, in_valid=1 → next cycle wb_data=0x1234, wb_addr=8, wb_reg_write=1; retire_count=1.
- mem_data=0x8077_F0AA, src=1, byte loads at offsets 0/3 → signed 0xFFFF_FFAA / 0xFFFF_FF80; unsigned 0xAA / 0x80. Halfword at offset 2, signed → 0xFFFF_8077.
- src=2, link_addr=0x0040_0008, wr_addr=31 → wb_data=0x0040_0008, wb_addr=31. With wr_addr=0 → wb_reg_write=0, wb_valid=1.
- Hold stall for 3 cycles while the inputs change → outputs frozen and the counter unchanged. stall and flush together → bubble: wb_valid=0, wb_data=0.
- CNT_W=4, 17 valid instructions → retire_count=1. Assert reset during a stall → all outputs 0 next cycle.
- Build without WB_LOAD_EXT_EN: src=1, mem_data=0x8077_F0AA, byte load → wb_data=0x8077_F0AA.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline encodings: writeback result source and load access size.
package mips_pkg;

    typedef enum logic [1:0] {
        WB_SRC_ALU  = 2'd0,
        WB_SRC_MEM  = 2'd1,
        WB_SRC_LINK = 2'd2,
        WB_SRC_RSVD = 2'd3
    } wb_src_e;

    typedef enum logic [1:0] {
        LD_BYTE  = 2'd0,
        LD_HALF  = 2'd1,
        LD_WORD  = 2'd2,
        LD_DWORD = 2'd3
    } ld_size_e;

endpackage

// File: rtl/load_extract.sv
// Sub-word load extraction: picks the addressed lane out of an aligned word/dword and extends it.
module load_extract
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OFF_W  = $clog2(DATA_W/8)
) (
    input  logic [DATA_W-1:0] mem_data,
    input  logic [1:0]        load_size,
    input  logic              load_unsigned,
    input  logic [OFF_W-1:0]  byte_off,
    output logic [DATA_W-1:0] ext_data
);

    logic [OFF_W-1:0]  alignedOff;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] mask;
    logic              signBit;

    always_comb begin
        alignedOff = byte_off;
        mask       = '1;
        signBit    = 1'b0;
        case (ld_size_e'(load_size))
            LD_BYTE: ;
            LD_HALF: alignedOff[0] = 1'b0;
            LD_WORD: alignedOff[1:0] = 2'b00;
            default: alignedOff = '0;
        endcase
        // Offset bits inside the lane were cleared above, so the shift lands on the lane start.
        shifted = mem_data >> {alignedOff, 3'b000};
        case (ld_size_e'(load_size))
            LD_BYTE: begin
                mask    = DATA_W'(8'hFF);
                signBit = shifted[7];
            end
            LD_HALF: begin
                mask    = DATA_W'(16'hFFFF);
                signBit = shifted[15];
            end
            LD_WORD: begin
                mask    = (DATA_W == 64) ? DATA_W'(32'hFFFF_FFFF) : '1;
                signBit = shifted[31];
            end
            default: ;
        endcase
        ext_data = (shifted & mask) | ((~load_unsigned & signBit) ? ~mask : '0);
    end

endmodule

// File: rtl/wb_stage_reg.sv
// MEM/WB pipeline register with writeback result mux and retire counter.
// WB_LOAD_EXT_EN enables sub-word load extraction; otherwise memory data passes through untouched.
module wb_stage_reg
    import mips_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int CNT_W   = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         stall,
    input  logic                         flush,
    input  logic                         in_valid,
    input  logic [DATA_W-1:0]            mem_data,
    input  logic [DATA_W-1:0]            alu_result,
    input  logic [DATA_W-1:0]            link_addr,
    input  logic [1:0]                   src_sel,
    input  logic [1:0]                   load_size,
    input  logic                         load_unsigned,
    input  logic [$clog2(DATA_W/8)-1:0]  byte_off,
    input  logic                         reg_write,
    input  logic [RADDR_W-1:0]           wr_addr,
    output logic                         wb_valid,
    output logic                         wb_reg_write,
    output logic [DATA_W-1:0]            wb_data,
    output logic [RADDR_W-1:0]           wb_addr,
    output logic [CNT_W-1:0]             retire_count
);

    logic [DATA_W-1:0] memVal;
    logic [DATA_W-1:0] resultVal;
    logic              regWriteNext;

`ifdef WB_LOAD_EXT_EN
    load_extract #(.DATA_W(DATA_W)) uLoadExtract (
        .mem_data      (mem_data),
        .load_size     (load_size),
        .load_unsigned (load_unsigned),
        .byte_off      (byte_off),
        .ext_data      (memVal)
    );
`else
    logic unusedLoadCtl;
    assign unusedLoadCtl = &{1'b0, load_size, load_unsigned, byte_off};
    assign memVal        = mem_data;
`endif

    always_comb begin
        case (wb_src_e'(src_sel))
            WB_SRC_MEM:  resultVal = memVal;
            WB_SRC_LINK: resultVal = link_addr;
            default:     resultVal = alu_result;
        endcase
    end

    // $zero is never written, regardless of what decode asked for.
    assign regWriteNext = reg_write & in_valid & (wr_addr != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_data      <= '0;
            wb_addr      <= '0;
            retire_count <= '0;
        end else if (flush) begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_data      <= '0;
            wb_addr      <= '0;
        end else if (!stall) begin
            wb_valid     <= in_valid;
            wb_reg_write <= regWriteNext;
            wb_data      <= resultVal;
            wb_addr      <= wr_addr;
            if (in_valid)
                retire_count <= retire_count + CNT_W'(1);
        end
    end

endmodule
